// File: rtl/wb_pkg.sv
// Shared types and widths for the Wishbone SRAM slave.
package wb_pkg;

    localparam int WB_DATA_W = 32;
    localparam int WB_SEL_W  = 4;
    localparam int WB_CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACK
    } wb_state_e;

endpackage

// File: rtl/wb_sram_core.sv
// Single-port SRAM array, per-byte write enables, registered read port.
module wb_sram_core
    import wb_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int ADDR_W      = $clog2(DEPTH_WORDS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 we,
    input  logic [WB_SEL_W-1:0]  sel,
    input  logic [ADDR_W-1:0]    addr,
    input  logic [WB_DATA_W-1:0] wdata,
    output logic [WB_DATA_W-1:0] rdata
);

    logic [WB_DATA_W-1:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (en && we) begin
            for (int i = 0; i < WB_SEL_W; i++) begin
                if (sel[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    // Read register holds its value across writes and idle cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= '0;
        end else if (en && !we) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/wb_sram_slave.sv
// Wishbone classic slave over on-chip SRAM with programmable wait states.
// Optional: define WB_SRAM_ERR_EN to error-ack out-of-range addresses.
module wb_sram_slave
    import wb_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_STATES = 0,
    parameter int          ADDR_W      = $clog2(DEPTH_WORDS)
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    input  logic [31:0]          wbs_adr_i,
    input  logic [WB_DATA_W-1:0] wbs_dat_i,
    output logic [WB_DATA_W-1:0] wbs_dat_o,
    input  logic                 wbs_we_i,
    input  logic [WB_SEL_W-1:0]  wbs_sel_i,
    input  logic                 wbs_stb_i,
    input  logic                 wbs_cyc_i,
    output logic                 wbs_ack_o,
    output logic                 wbs_err_o
);

    localparam logic [WB_CNT_W-1:0] WS_LOAD =
        (WAIT_STATES > 0) ? WB_CNT_W'(WAIT_STATES - 1) : '0;

    wb_state_e             state_q;
    wb_state_e             state_d;
    logic [WB_CNT_W-1:0]   cnt_q;
    logic [WB_CNT_W-1:0]   cnt_d;
    logic [ADDR_W-1:0]     idx_q;
    logic                  we_q;
    logic [WB_SEL_W-1:0]   sel_q;
    logic [WB_DATA_W-1:0]  dat_q;
    logic                  oor_q;

    logic                  req;
    logic                  in_idle;
    logic                  commit;
    logic [31:0]           off;
    logic [ADDR_W-1:0]     idx_in;
    logic                  oor_in;

    logic [ADDR_W-1:0]     m_idx;
    logic                  m_we;
    logic [WB_SEL_W-1:0]   m_sel;
    logic [WB_DATA_W-1:0]  m_dat;
    logic                  m_oor;
    logic                  core_en;

    assign req     = wbs_cyc_i & wbs_stb_i;
    assign in_idle = (state_q == IDLE);
    assign off     = wbs_adr_i - BASE_ADDR;
    assign idx_in  = off[ADDR_W+1:2];

`ifdef WB_SRAM_ERR_EN
    logic unused_off;
    assign unused_off = ^off[1:0];
    assign oor_in     = |off[31:ADDR_W+2];
`else
    logic unused_off;
    assign unused_off = ^{off[31:ADDR_W+2], off[1:0]};
    assign oor_in     = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        commit  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    cnt_d = WS_LOAD;
                    if (WAIT_STATES > 0) begin
                        state_d = WAIT;
                    end else begin
                        state_d = ACK;
                        commit  = 1'b1;
                    end
                end
            end
            WAIT: begin
                if (!wbs_cyc_i) begin
                    state_d = IDLE;
                end else if (cnt_q == '0) begin
                    state_d = ACK;
                    commit  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            idx_q <= '0;
            we_q  <= 1'b0;
            sel_q <= '0;
            dat_q <= '0;
            oor_q <= 1'b0;
        end else if (in_idle && req) begin
            idx_q <= idx_in;
            we_q  <= wbs_we_i;
            sel_q <= wbs_sel_i;
            dat_q <= wbs_dat_i;
            oor_q <= oor_in;
        end
    end

    // With zero wait states the array is hit on the capture edge itself.
    assign m_idx = in_idle ? idx_in    : idx_q;
    assign m_we  = in_idle ? wbs_we_i  : we_q;
    assign m_sel = in_idle ? wbs_sel_i : sel_q;
    assign m_dat = in_idle ? wbs_dat_i : dat_q;
    assign m_oor = in_idle ? oor_in    : oor_q;

    assign core_en = commit & ~m_oor & ~wb_rst_i;

    wb_sram_core #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .ADDR_W      (ADDR_W)
    ) u_core (
        .clk   (wb_clk_i),
        .rst   (wb_rst_i),
        .en    (core_en),
        .we    (m_we),
        .sel   (m_sel),
        .addr  (m_idx),
        .wdata (m_dat),
        .rdata (wbs_dat_o)
    );

    assign wbs_ack_o = (state_q == ACK) & ~oor_q;
    assign wbs_err_o = (state_q == ACK) &  oor_q;

endmodule

// File: tb/tb_wb_sram_slave.sv
// Scoreboard bench: one slave with zero wait states, one with three.
module tb_wb_sram_slave;

    typedef struct {
        logic [31:0] dat;
        logic        err;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst  [2];
    logic [31:0] adr  [2];
    logic [31:0] wdat [2];
    logic [31:0] rdat [2];
    logic        we   [2];
    logic [3:0]  sel  [2];
    logic        stb  [2];
    logic        cyc  [2];
    logic        ack  [2];
    logic        err  [2];

    int          cyc_cnt = 0;
    int          checks = 0;
    int          failures = 0;
    logic [31:0] last_rd [2];
    exp_t        sb0 [$];
    exp_t        sb1 [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    wb_sram_slave #(
        .DEPTH_WORDS (1024),
        .BASE_ADDR   (32'h0),
        .WAIT_STATES (0)
    ) u_ws0 (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst[0]),
        .wbs_adr_i (adr[0]),
        .wbs_dat_i (wdat[0]),
        .wbs_dat_o (rdat[0]),
        .wbs_we_i  (we[0]),
        .wbs_sel_i (sel[0]),
        .wbs_stb_i (stb[0]),
        .wbs_cyc_i (cyc[0]),
        .wbs_ack_o (ack[0]),
        .wbs_err_o (err[0])
    );

    wb_sram_slave #(
        .DEPTH_WORDS (1024),
        .BASE_ADDR   (32'h0),
        .WAIT_STATES (3)
    ) u_ws3 (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst[1]),
        .wbs_adr_i (adr[1]),
        .wbs_dat_i (wdat[1]),
        .wbs_dat_o (rdat[1]),
        .wbs_we_i  (we[1]),
        .wbs_sel_i (sel[1]),
        .wbs_stb_i (stb[1]),
        .wbs_cyc_i (cyc[1]),
        .wbs_ack_o (ack[1]),
        .wbs_err_o (err[1])
    );

    function automatic int ws(input int k);
        return (k == 0) ? 0 : 3;
    endfunction

    task automatic chk_resp(input int k, input exp_t e);
        checks++;
        if (ack[k] !== !e.err || err[k] !== e.err ||
            rdat[k] !== e.dat || cyc_cnt != e.cyc) begin
            failures++;
            $display("FAIL resp dut%0d got ack=%0b err=%0b dat=%h cyc=%0d want ack=%0b err=%0b dat=%h cyc=%0d",
                     k, ack[k], err[k], rdat[k], cyc_cnt,
                     !e.err, e.err, e.dat, e.cyc);
        end
    endtask

    // Monitor: every ack/err pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (ack[k] === 1'b1 || err[k] === 1'b1) begin
                if (k == 0 && sb0.size() > 0) begin
                    chk_resp(0, sb0.pop_front());
                end else if (k == 1 && sb1.size() > 0) begin
                    chk_resp(1, sb1.pop_front());
                end else begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_ack dut%0d ack=%0b err=%0b cyc=%0d want none",
                             k, ack[k], err[k], cyc_cnt);
                end
            end
        end
    end

    task automatic xfer(input int k, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] s,
                        input logic [31:0] exp_rd, input logic exp_err);
        exp_t e;
        int   n;
        @(posedge clk);
        #1;
        if (!w && !exp_err) begin
            e.dat      = exp_rd;
            last_rd[k] = exp_rd;
        end else begin
            e.dat = last_rd[k];
        end
        e.err = exp_err;
        e.cyc = cyc_cnt + 1 + ws(k);
        if (k == 0) sb0.push_back(e);
        else sb1.push_back(e);
        adr[k]  = a;
        wdat[k] = d;
        sel[k]  = s;
        we[k]   = w;
        cyc[k]  = 1'b1;
        stb[k]  = 1'b1;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!(ack[k] || err[k]) && n < 40);
        if (!(ack[k] || err[k])) begin
            checks++;
            failures++;
            $display("FAIL timeout dut%0d adr=%h got no ack want ack", k, a);
        end
        cyc[k] = 1'b0;
        stb[k] = 1'b0;
        we[k]  = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (ack[k] !== 1'b0 || err[k] !== 1'b0) begin
            failures++;
            $display("FAIL pulse_width dut%0d got ack=%0b err=%0b want 0 0",
                     k, ack[k], err[k]);
        end
    endtask

    // Start a write, then abandon it in cycle 2: by dropping cyc or by reset.
    task automatic abort_wr(input int k, input logic [31:0] a,
                            input logic [31:0] d, input logic use_rst);
        @(posedge clk);
        #1;
        adr[k]  = a;
        wdat[k] = d;
        sel[k]  = 4'hF;
        we[k]   = 1'b1;
        cyc[k]  = 1'b1;
        stb[k]  = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        if (use_rst) begin
            rst[k] = 1'b1;
            #1;
            checks++;
            if (ack[k] !== 1'b0 || err[k] !== 1'b0 || rdat[k] !== 32'h0) begin
                failures++;
                $display("FAIL reset_outputs dut%0d got ack=%0b err=%0b dat=%h want 0 0 0",
                         k, ack[k], err[k], rdat[k]);
            end
            last_rd[k] = 32'h0;
        end
        cyc[k] = 1'b0;
        stb[k] = 1'b0;
        we[k]  = 1'b0;
        @(posedge clk);
        #1;
        rst[k] = 1'b0;
        repeat (8) @(posedge clk);
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            rst[k]  = 1'b1;
            adr[k]  = '0;
            wdat[k] = '0;
            we[k]   = 1'b0;
            sel[k]  = '0;
            stb[k]  = 1'b0;
            cyc[k]  = 1'b0;
            last_rd[k] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (ack[k] !== 1'b0 || err[k] !== 1'b0 || rdat[k] !== 32'h0) begin
                failures++;
                $display("FAIL reset_state dut%0d got ack=%0b err=%0b dat=%h want 0 0 0",
                         k, ack[k], err[k], rdat[k]);
            end
        end
        rst[0] = 1'b0;
        rst[1] = 1'b0;

        xfer(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0);
        xfer(0, 1'b0, 32'h10, 32'h0, 4'hF, 32'hDEAD_BEEF, 1'b0);

        xfer(0, 1'b1, 32'h20, 32'hFFFF_FFFF, 4'hF, 32'h0, 1'b0);
        xfer(0, 1'b1, 32'h20, 32'h1122_3344, 4'b0101, 32'h0, 1'b0);
        xfer(0, 1'b0, 32'h20, 32'h0, 4'h0, 32'hFF22_FF44, 1'b0);

        xfer(0, 1'b1, 32'h30, 32'hA5A5_5A5A, 4'hF, 32'h0, 1'b0);
        xfer(0, 1'b0, 32'h30, 32'h0, 4'h0, 32'hA5A5_5A5A, 1'b0);
        xfer(0, 1'b1, 32'h32, 32'h0000_0000, 4'h0, 32'h0, 1'b0);
        xfer(0, 1'b0, 32'h33, 32'h0, 4'h0, 32'hA5A5_5A5A, 1'b0);

        xfer(0, 1'b1, 32'h0, 32'h1234_5678, 4'hF, 32'h0, 1'b0);
`ifdef WB_SRAM_ERR_EN
        xfer(0, 1'b0, 32'h1000, 32'h0, 4'h0, 32'h0, 1'b1);
        xfer(0, 1'b1, 32'h1000, 32'hFFFF_FFFF, 4'hF, 32'h0, 1'b1);
        xfer(0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h1234_5678, 1'b0);
`else
        xfer(0, 1'b0, 32'h1000, 32'h0, 4'h0, 32'h1234_5678, 1'b0);
        xfer(0, 1'b1, 32'h1004, 32'hCAFE_F00D, 4'hF, 32'h0, 1'b0);
        xfer(0, 1'b0, 32'h4, 32'h0, 4'h0, 32'hCAFE_F00D, 1'b0);
`endif

        xfer(1, 1'b1, 32'h40, 32'h0102_0304, 4'hF, 32'h0, 1'b0);
        xfer(1, 1'b0, 32'h40, 32'h0, 4'h0, 32'h0102_0304, 1'b0);
        abort_wr(1, 32'h40, 32'hFFFF_FFFF, 1'b0);
        xfer(1, 1'b0, 32'h40, 32'h0, 4'h0, 32'h0102_0304, 1'b0);

        xfer(1, 1'b1, 32'h44, 32'h55AA_55AA, 4'hF, 32'h0, 1'b0);
        abort_wr(1, 32'h44, 32'h0000_0000, 1'b1);
        xfer(1, 1'b0, 32'h44, 32'h0, 4'h0, 32'h55AA_55AA, 1'b0);
        xfer(1, 1'b1, 32'h48, 32'h0BAD_F00D, 4'hF, 32'h0, 1'b0);
        xfer(1, 1'b0, 32'h48, 32'h0, 4'h0, 32'h0BAD_F00D, 1'b0);

        repeat (4) @(posedge clk);
        checks++;
        if (sb0.size() != 0 || sb1.size() != 0) begin
            failures++;
            $display("FAIL pending_responses got %0d/%0d want 0/0",
                     sb0.size(), sb1.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got no finish want finish by 200000");
        $fatal(1, "watchdog");
    end

endmodule
